io_intc: RTL and testbench

IO_INTC -- requirements
Module: io_intc

---
 rtl/intc_pkg.sv | 34 +++
 rtl/intc_prio_enc.sv | 30 +++
 rtl/io_intc.sv | 134 +++++++++++++
 tb/tb_io_intc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module : intc_pkg
// Brief  : Shared types and constants for the io_intc interrupt controller.
// Rev    : 1.0  initial release
// ============================================================================
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK     = 2'd2,
    ST_SERVICE = 2'd3
  } intc_state_e;

  localparam logic [3:0] INTC_MASK_ADDR = 4'hE;
  localparam int         IDX_W          = 4;

  // Status word layout seen on d_bus during io_push_ints.
  localparam int STAT_PEND_LSB = 0;
  localparam int STAT_MASK_LSB = 8;
  localparam int STAT_FIELD_W  = 8;

  function automatic logic [15:0] pack_status(input logic [STAT_FIELD_W-1:0] mask,
                                               input logic [STAT_FIELD_W-1:0] pend);
    logic [15:0] s;
    s = '0;
    s[STAT_MASK_LSB +: STAT_FIELD_W] = mask;
    s[STAT_PEND_LSB +: STAT_FIELD_W] = pend;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module : intc_prio_enc
// Brief  : Combinational lowest-index-first priority encoder with valid flag.
// Rev    : 1.0  initial release
// ============================================================================
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_intc.sv
`default_nettype none
// ============================================================================
// Module : io_intc
// Brief  : Edge-triggered, maskable, non-nesting vectored interrupt controller.
//          Define INTC_SYNC_EN to add two-flop synchronizers on every irq line.
// Rev    : 1.0  initial release
// ============================================================================
module io_intc
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] VECTOR_BASE  = 16'h0100,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               io_interrupt,
  input  logic               io_store_retaddr,
  input  logic               io_push_retaddr,
  input  logic               io_push_ints,
  input  logic               io_push_int_addr,
  input  logic               io_write,
  input  logic [15:0]        d_addr,
  inout  wire  [15:0]        d_bus
);

  intc_state_e        r_state, w_next;
  logic [NUM_IRQ-1:0] r_pending, r_mask, r_irq_prev;
  logic [NUM_IRQ-1:0] w_irq_s, w_edge, w_active, w_clr;
  logic               r_armed, r_interrupt;
  logic               w_valid, w_ack, w_mask_wr, w_ret_eff, w_drive;
  logic [IDX_W-1:0]   r_sel, w_sel;
  logic [15:0]        r_retaddr, w_vector, w_status, w_dout;
  logic               w_unused;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq;
`endif

  // r_armed masks the first post-reset cycle so lines already high are not seen as edges.
  assign w_edge    = w_irq_s & ~r_irq_prev & {NUM_IRQ{r_armed}};
  assign w_active  = r_pending & r_mask;
  assign w_vector  = VECTOR_BASE + (16'(r_sel) << VECTOR_SHIFT);
  assign w_status  = pack_status(8'(r_mask), 8'(r_pending));
  assign w_mask_wr = io_write && (d_addr[3:0] == INTC_MASK_ADDR);
  assign w_ret_eff = io_push_retaddr && !io_push_int_addr;
  assign w_clr     = w_ack ? (NUM_IRQ'(1) << r_sel) : '0;
  assign w_unused  = ^d_addr[15:4];

  intc_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .i_req   (w_active),
    .o_idx   (w_sel),
    .o_valid (w_valid)
  );

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_valid) w_next = ST_REQ;
      ST_REQ: begin
        if (io_push_int_addr) begin
          w_next = ST_ACK;
          w_ack  = 1'b1;
        end else if (!w_valid) begin
          w_next = ST_IDLE;
        end
      end
      ST_ACK:     if (io_store_retaddr) w_next = ST_SERVICE;
      ST_SERVICE: if (w_ret_eff) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // A single driver per cycle, chosen by strobe priority regardless of state.
  always_comb begin
    w_drive = 1'b0;
    w_dout  = '0;
    if (io_push_int_addr) begin
      w_drive = 1'b1;
      w_dout  = w_vector;
    end else if (io_push_retaddr) begin
      w_drive = 1'b1;
      w_dout  = r_retaddr;
    end else if (io_push_ints) begin
      w_drive = 1'b1;
      w_dout  = w_status;
    end
    w_drive = w_drive & rst_n;
  end

  assign d_bus = w_drive ? w_dout : 16'hzzzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_interrupt <= 1'b0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_irq_prev  <= '0;
      r_armed     <= 1'b0;
      r_sel       <= '0;
      r_retaddr   <= 16'h0000;
    end else begin
      r_state     <= w_next;
      r_interrupt <= (w_next == ST_REQ);
      r_irq_prev  <= w_irq_s;
      r_armed     <= 1'b1;
      r_pending   <= (r_pending & ~w_clr) | w_edge;
      if (w_mask_wr)                           r_mask    <= d_bus[NUM_IRQ-1:0];
      if (r_state == ST_IDLE && w_valid)       r_sel     <= w_sel;
      if (r_state == ST_ACK && io_store_retaddr) r_retaddr <= d_bus;
    end
  end

  assign io_interrupt = r_interrupt;

endmodule
`default_nettype wire

// File: tb/tb_io_intc.sv
`default_nettype none
// ============================================================================
// Module : tb_io_intc
// Brief  : Self-checking bench for io_intc against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_io_intc;
  localparam int NIRQ = 8;
`ifdef INTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic            io_interrupt;
  logic            io_store_retaddr = 1'b0, io_push_retaddr = 1'b0, io_push_ints = 1'b0;
  logic            io_push_int_addr = 1'b0, io_write = 1'b0;
  logic [15:0]     d_addr = '0;
  wire  [15:0]     d_bus;
  logic [15:0]     tb_bus = '0;
  logic            tb_drv = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: pending/mask sets, last return address, last frozen vector.
  logic [7:0]  m_pend = '0, m_mask = '0;
  logic [15:0] m_ret = '0, m_vec = 16'h0100;

  assign d_bus = tb_drv ? tb_bus : 16'hzzzz;

  io_intc dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq              (irq),
    .io_interrupt     (io_interrupt),
    .io_store_retaddr (io_store_retaddr),
    .io_push_retaddr  (io_push_retaddr),
    .io_push_ints     (io_push_ints),
    .io_push_int_addr (io_push_int_addr),
    .io_write         (io_write),
    .d_addr           (d_addr),
    .d_bus            (d_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int model_sel();
    for (int i = 0; i < NIRQ; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] vec_of(input int idx);
    return 16'h0100 + 16'(idx * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    irq = b;
    tick();
    irq = '0;
    repeat (LAT) tick();
    m_pend = m_pend | b;
  endtask

  task automatic write_mask(input logic [7:0] m);
    d_addr   = {12'($urandom), 4'hE};
    tb_bus   = {8'($urandom), m};
    tb_drv   = 1'b1;
    io_write = 1'b1;
    tick();
    io_write = 1'b0;
    tb_drv   = 1'b0;
    m_mask   = m;
  endtask

  task automatic read_status(output logic [15:0] v);
    io_push_ints = 1'b1;
    #2 v = d_bus;
    io_push_ints = 1'b0;
    #1;
  endtask

  task automatic push_vec(output logic [15:0] v);
    io_push_int_addr = 1'b1;
    #2 v = d_bus;
    tick();
    io_push_int_addr = 1'b0;
  endtask

  task automatic store_ret(input logic [15:0] a);
    tb_bus = a;
    tb_drv = 1'b1;
    io_store_retaddr = 1'b1;
    tick();
    io_store_retaddr = 1'b0;
    tb_drv = 1'b0;
    m_ret  = a;
  endtask

  task automatic push_ret(output logic [15:0] v);
    io_push_retaddr = 1'b1;
    #2 v = d_bus;
    tick();
    io_push_retaddr = 1'b0;
  endtask

  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (io_interrupt === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_ret = '0; m_vec = 16'h0100;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0;
`ifndef INTC_SYNC_EN
    irq = 8'h04;
`endif
    repeat (2) tick();
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=0", io_interrupt); end
    rst_n = 1'b1;
    repeat (3) tick();
    read_status(v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", v); end
    irq = '0;
    tick();
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL reset_noedge_int got=%b exp=0", io_interrupt); end
    model_reset();
  endtask

  task automatic test_single();
    logic [15:0] v;
    write_mask(8'hFF);
    irq = 8'h08;
    for (int i = 1; i < LAT; i++) begin
      tick();
      read_status(v);
      total++; if (v !== 16'hFF00) begin bad++; $display("FAIL sync_early got=%h exp=FF00", v); end
    end
    tick();
    read_status(v);
    total++; if (v !== 16'hFF08) begin bad++; $display("FAIL single_pend got=%h exp=FF08", v); end
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL single_int_early got=%b exp=0", io_interrupt); end
    irq = '0;
    tick();
    total++; if (io_interrupt !== 1'b1) begin bad++; $display("FAIL single_int got=%b exp=1", io_interrupt); end
    m_pend = m_pend | 8'h08;
    push_vec(v);
    total++; if (v !== 16'h010C) begin bad++; $display("FAIL single_vec got=%h exp=010C", v); end
    m_pend[3] = 1'b0; m_vec = 16'h010C;
    read_status(v);
    total++; if (v !== 16'hFF00) begin bad++; $display("FAIL single_ack_clr got=%h exp=FF00", v); end
    store_ret(16'hA5A5);
    push_ret(v);
    total++; if (v !== 16'hA5A5) begin bad++; $display("FAIL single_ret got=%h exp=A5A5", v); end
  endtask

  task automatic test_priority();
    logic [15:0] v; bit ok;
    pulse(8'h22);
    wait_int(ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_wait1 got=timeout exp=int"); end
    push_vec(v);
    total++; if (v !== 16'h0104) begin bad++; $display("FAIL prio_vec1 got=%h exp=0104", v); end
    m_pend[1] = 1'b0;
    store_ret(16'h2000);
    push_ret(v);
    wait_int(ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_wait2 got=timeout exp=int"); end
    push_vec(v);
    total++; if (v !== 16'h0114) begin bad++; $display("FAIL prio_vec2 got=%h exp=0114", v); end
    m_pend[5] = 1'b0; m_vec = 16'h0114;
    store_ret(16'h2002);
    push_ret(v);
  endtask

  task automatic test_mask();
    logic [15:0] v; bit ok; bit seen;
    write_mask(8'h00);
    pulse(8'h04);
    seen = 1'b0;
    repeat (4) begin tick(); if (io_interrupt !== 1'b0) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL mask_block got=int exp=no_int"); end
    d_addr = 16'h000D; tb_bus = 16'h00FF; tb_drv = 1'b1; io_write = 1'b1;
    tick();
    io_write = 1'b0; tb_drv = 1'b0;
    read_status(v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL mask_status got=%h exp=0004", v); end
    write_mask(8'h04);
    wait_int(ok);
    total++; if (!ok) begin bad++; $display("FAIL mask_unblock got=timeout exp=int"); end
    push_vec(v);
    total++; if (v !== 16'h0108) begin bad++; $display("FAIL mask_vec got=%h exp=0108", v); end
    m_pend[2] = 1'b0; m_vec = 16'h0108;
    store_ret(16'h3000);
    push_ret(v);
  endtask

  task automatic test_nesting();
    logic [15:0] v; bit ok; bit seen;
    write_mask(8'hFF);
    pulse(8'h40);
    wait_int(ok);
    push_vec(v);
    m_pend[6] = 1'b0; m_vec = 16'h0118;
    store_ret(16'h1234);
    pulse(8'h01);
    seen = 1'b0;
    repeat (3) begin tick(); if (io_interrupt !== 1'b0) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL nest_int_in_service got=int exp=no_int"); end
    push_ret(v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL nest_ret got=%h exp=1234", v); end
    wait_int(ok);
    total++; if (!ok) begin bad++; $display("FAIL nest_after got=timeout exp=int"); end
    push_vec(v);
    total++; if (v !== 16'h0100) begin bad++; $display("FAIL nest_vec got=%h exp=0100", v); end
    m_pend[0] = 1'b0; m_vec = 16'h0100;
    store_ret(16'h1300);
    push_ret(v);
  endtask

  task automatic test_withdraw();
    logic [15:0] v; bit ok;
    pulse(8'h40);
    wait_int(ok);
    m_vec = 16'h0118;
    write_mask(8'h00);
    repeat (2) tick();
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL withdraw_int got=%b exp=0", io_interrupt); end
    read_status(v);
    total++; if (v !== 16'h0040) begin bad++; $display("FAIL withdraw_pend got=%h exp=0040", v); end
    write_mask(8'hFF);
    wait_int(ok);
    push_vec(v);
    total++; if (v !== 16'h0118) begin bad++; $display("FAIL withdraw_vec got=%h exp=0118", v); end
    m_pend[6] = 1'b0;
    store_ret(16'h4444);
    push_ret(v);
  endtask

  task automatic test_invalid_push();
    logic [15:0] v; bit ok;
    write_mask(8'h00);
    pulse(8'h80);
    io_push_ints = 1'b1; io_push_retaddr = 1'b1;
    #2 v = d_bus;
    tick();
    io_push_ints = 1'b0; io_push_retaddr = 1'b0;
    total++; if (v !== m_ret) begin bad++; $display("FAIL prio_ret_over_ints got=%h exp=%h", v, m_ret); end
    io_push_int_addr = 1'b1; io_push_retaddr = 1'b1; io_push_ints = 1'b1;
    #2 v = d_bus;
    tick();
    io_push_int_addr = 1'b0; io_push_retaddr = 1'b0; io_push_ints = 1'b0;
    total++; if (v !== m_vec) begin bad++; $display("FAIL prio_vec_over_all got=%h exp=%h", v, m_vec); end
    tick();
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL invalid_int got=%b exp=0", io_interrupt); end
    read_status(v);
    total++; if (v !== 16'h0080) begin bad++; $display("FAIL invalid_status got=%h exp=0080", v); end
    write_mask(8'hFF);
    wait_int(ok);
    push_vec(v);
    total++; if (v !== 16'h011C) begin bad++; $display("FAIL invalid_vec got=%h exp=011C", v); end
    m_pend[7] = 1'b0; m_vec = 16'h011C;
    store_ret(16'h5555);
    push_ret(v);
  endtask

  task automatic test_ack_edge();
    logic [15:0] v; bit ok;
    pulse(8'h04);
    wait_int(ok);
    io_push_int_addr = 1'b1;
    irq = 8'h04;
    #2 v = d_bus;
    tick();
    io_push_int_addr = 1'b0;
    irq = '0;
    total++; if (v !== 16'h0108) begin bad++; $display("FAIL ackedge_vec got=%h exp=0108", v); end
    repeat (LAT) tick();
    read_status(v);
    total++; if (v !== 16'hFF04) begin bad++; $display("FAIL ackedge_pend got=%h exp=FF04", v); end
    store_ret(16'h6666);
    push_ret(v);
    wait_int(ok);
    push_vec(v);
    total++; if (v !== 16'h0108) begin bad++; $display("FAIL ackedge_vec2 got=%h exp=0108", v); end
    m_pend[2] = 1'b0; m_vec = 16'h0108;
    store_ret(16'h6668);
    push_ret(v);
  endtask

  task automatic test_reset_service();
    logic [15:0] v; bit ok;
    pulse(8'h10);
    wait_int(ok);
    #2 rst_n = 1'b0;
    #1;
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL async_reset_int got=%b exp=0", io_interrupt); end
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    write_mask(8'hFF);
    pulse(8'h20);
    wait_int(ok);
    push_vec(v);
    store_ret(16'hBEEF);
    pulse(8'h03);
    #2 rst_n = 1'b0;
    #1;
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL svc_reset_int got=%b exp=0", io_interrupt); end
    tick();
    rst_n = 1'b1;
    model_reset();
    repeat (2) tick();
    read_status(v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL svc_reset_status got=%h exp=0000", v); end
    push_ret(v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL svc_reset_ret got=%h exp=0000", v); end
    tick();
    total++; if (io_interrupt !== 1'b0) begin bad++; $display("FAIL svc_reset_idle got=%b exp=0", io_interrupt); end
  endtask

  task automatic test_random();
    logic [15:0] v, r; bit ok; int idx, guard;
    for (int it = 0; it < 30; it++) begin
      write_mask(8'h00);
      pulse(8'($urandom));
      write_mask(8'($urandom));
      read_status(v);
      total++; if (v !== {m_mask, m_pend}) begin bad++; $display("FAIL rnd_status got=%h exp=%h", v, {m_mask, m_pend}); end
      guard = 0;
      while (model_sel() >= 0 && guard < 16) begin
        guard++;
        wait_int(ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_wait got=timeout exp=int"); break; end
        idx = model_sel();
        push_vec(v);
        total++; if (v !== vec_of(idx)) begin bad++; $display("FAIL rnd_vec got=%h exp=%h", v, vec_of(idx)); end
        m_pend[idx] = 1'b0; m_vec = vec_of(idx);
        r = 16'($urandom);
        store_ret(r);
        push_ret(v);
        total++; if (v !== r) begin bad++; $display("FAIL rnd_ret got=%h exp=%h", v, r); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_nesting();
    test_withdraw();
    test_invalid_push();
    test_ack_edge();
    test_reset_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
